// File: rtl/fsub_arbiter.sv
// Round-robin share of one combinational fsub among NREQ valid/ready requesters; optional perf counters under FSUB_ARB_PERF_EN.
// Latency: handshake at edge T -> rsp_valid after edge T+1; 1 op/cycle sustained.
// Backpressure: stalled result holds RES, then ISS; req_ready all low while both stages are full.
module fsub_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_y,
    output logic                 rsp_ovf,
    output logic [31:0]          fsub_x1,
    output logic [31:0]          fsub_x2,
    input  logic [31:0]          fsub_y,
    input  logic                 fsub_ovf,
    output logic                 busy
`ifdef FSUB_ARB_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [15:0]          perf_ovf
`endif
);

    logic            r_iss_full;
    logic [31:0]     r_iss_x1;
    logic [31:0]     r_iss_x2;
    logic [IDW-1:0]  r_iss_id;
    logic            r_res_full;
    logic [31:0]     r_res_y;
    logic            r_res_ovf;
    logic [IDW-1:0]  r_res_id;
    logic [IDW-1:0]  r_ptr;

    logic            w_adv_res;
    logic            w_adv_iss;
    logic            w_hit;
    logic            w_take;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_cand;
    int              w_idx;

    assign w_adv_res = ~r_res_full | rsp_ready;
    assign w_adv_iss = ~r_iss_full | w_adv_res;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        w_hit  = 1'b0;
        w_win  = '0;
        w_idx  = 0;
        w_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_cand = IDW'(w_idx);
            if (!w_hit && req_valid[w_cand]) begin
                w_hit = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_take = w_hit & w_adv_iss & ~rst;

    always_comb begin
        req_ready = '0;
        if (w_take) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_full <= 1'b0;
            r_iss_x1   <= '0;
            r_iss_x2   <= '0;
            r_iss_id   <= '0;
            r_ptr      <= '0;
        end else if (w_take) begin
            r_iss_full <= 1'b1;
            r_iss_x1   <= req_x1[32*w_win +: 32];
            r_iss_x2   <= req_x2[32*w_win +: 32];
            r_iss_id   <= w_win;
            r_ptr      <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end else if (w_adv_iss) begin
            r_iss_full <= 1'b0;
        end
    end

    // The fsub is combinational, so its result is captured straight into RES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_full <= 1'b0;
            r_res_y    <= '0;
            r_res_ovf  <= 1'b0;
            r_res_id   <= '0;
        end else if (r_iss_full && w_adv_res) begin
            r_res_full <= 1'b1;
            r_res_y    <= fsub_y;
            r_res_ovf  <= fsub_ovf;
            r_res_id   <= r_iss_id;
        end else if (rsp_ready) begin
            r_res_full <= 1'b0;
        end
    end

    assign fsub_x1   = r_iss_x1;
    assign fsub_x2   = r_iss_x2;
    assign rsp_valid = r_res_full;
    assign rsp_id    = r_res_id;
    assign rsp_y     = r_res_y;
    assign rsp_ovf   = r_res_ovf;
    assign busy      = r_iss_full | r_res_full;

`ifdef FSUB_ARB_PERF_EN
    logic        w_rsp_hs;
    logic [31:0] r_perf_ops;
    logic [15:0] r_perf_ovf;

    assign w_rsp_hs = r_res_full & rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_ops <= '0;
            r_perf_ovf <= '0;
        end else if (w_rsp_hs) begin
            r_perf_ops <= r_perf_ops + 32'd1;
            if (r_res_ovf && (r_perf_ovf != 16'hFFFF)) begin
                r_perf_ovf <= r_perf_ovf + 16'd1;
            end
        end
    end

    assign perf_ops = r_perf_ops;
    assign perf_ovf = r_perf_ovf;
`endif

endmodule

// File: tb/tb_fsub_arbiter.sv
// Randomized and directed bench for fsub_arbiter against a queue-based pipeline model.
module tb_fsub_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_x1;
    logic [127:0] req_x2;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_y;
    logic         rsp_ovf;
    logic [31:0]  fsub_x1;
    logic [31:0]  fsub_x2;
    logic [31:0]  fsub_y;
    logic         fsub_ovf;
    logic         busy;
`ifdef FSUB_ARB_PERF_EN
    logic [31:0]  perf_ops;
    logic [15:0]  perf_ovf;
`endif

    fsub_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
        .fsub_x1(fsub_x1), .fsub_x2(fsub_x2), .fsub_y(fsub_y), .fsub_ovf(fsub_ovf),
        .busy(busy)
`ifdef FSUB_ARB_PERF_EN
        , .perf_ops(perf_ops), .perf_ovf(perf_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the shared fsub: exact results for the directed operand pairs,
    // an arbitrary but deterministic function otherwise.
    function automatic logic [32:0] fsub_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h3F000000) return {1'b0, 32'h3F000000};
        if (a == 32'h7F7FFFFF && b == 32'hFF7FFFFF) return {1'b1, 32'h7F800000};
        if (a == 32'h40000000 && b == 32'h3F800000) return {1'b0, 32'h3F800000};
        return {a[31] & b[30], a - b};
    endfunction

    assign {fsub_ovf, fsub_y} = fsub_fn(fsub_x1, fsub_x2);

    typedef struct {
        logic [1:0]  id;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
        logic        ovf;
    } op_t;

    op_t         q[$];
    bit          m_res_full;
    int          m_ptr;
    logic [3:0]  pend;
    logic [31:0] nx1[4];
    logic [31:0] nx2[4];
    int          n_chk = 0;
    int          n_pass = 0;
    int          dut_hs;
    logic [31:0] m_ops;
    logic [15:0] m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_rsp_y",     rsp_y,          32'd0);
        chk("rst_rsp_ovf",   32'(rsp_ovf),   32'd0);
        chk("rst_fsub_x1",   fsub_x1,        32'd0);
        chk("rst_fsub_x2",   fsub_x2,        32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
`ifdef FSUB_ARB_PERF_EN
        chk("rst_perf_ops",  perf_ops,       32'd0);
        chk("rst_perf_ovf",  32'(perf_ovf),  32'd0);
`endif
        q.delete();
        m_res_full = 1'b0;
        m_ptr      = 0;
        pend       = '0;
        m_ops      = '0;
        m_ovf      = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive inputs (pending requesters keep valid and operands),
    // compare every output with the model, then advance the model across the edge.
    task automatic do_cycle(input logic [3:0] want, input logic rr);
        bit         g;
        int         gid;
        int         idx;
        bit         iss_full;
        bit         adv_res;
        bit         adv_iss;
        logic [3:0] exp_rdy;
        op_t        o;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!pend[i]) begin
                req_valid[i] = want[i];
                if (want[i]) begin
                    req_x1[32*i +: 32] = nx1[i];
                    req_x2[32*i +: 32] = nx2[i];
                end
            end
        end
        rsp_ready = rr;
        #1;
        iss_full = q.size() > (m_res_full ? 1 : 0);
        adv_res  = !m_res_full || rr;
        adv_iss  = !iss_full || adv_res;
        g   = 1'b0;
        gid = 0;
        if (adv_iss) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!g && req_valid[idx]) begin
                    g   = 1'b1;
                    gid = idx;
                end
            end
        end
        exp_rdy = '0;
        if (g) exp_rdy[gid] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_res_full));
        chk("busy",      32'(busy),      32'(q.size() != 0));
        if (m_res_full) begin
            chk("rsp_id",  32'(rsp_id),  32'(q[0].id));
            chk("rsp_y",   rsp_y,        q[0].y);
            chk("rsp_ovf", 32'(rsp_ovf), 32'(q[0].ovf));
        end
        if (iss_full) begin
            chk("fsub_x1", fsub_x1, q[q.size()-1].x1);
            chk("fsub_x2", fsub_x2, q[q.size()-1].x2);
        end
`ifdef FSUB_ARB_PERF_EN
        chk("perf_ops", perf_ops,       m_ops);
        chk("perf_ovf", 32'(perf_ovf),  32'(m_ovf));
`endif
        if (rsp_valid && rr) dut_hs++;
        if (m_res_full && rr) begin
            o = q.pop_front();
            m_ops = m_ops + 32'd1;
            if (o.ovf && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
        end
        m_res_full = (m_res_full && !rr) || (iss_full && adv_res);
        if (g) begin
            o.id = 2'(gid);
            o.x1 = req_x1[32*gid +: 32];
            o.x2 = req_x2[32*gid +: 32];
            {o.ovf, o.y} = fsub_fn(o.x1, o.x2);
            q.push_back(o);
            m_ptr = (gid + 1) % 4;
        end
        for (int i = 0; i < 4; i++) pend[i] = req_valid[i] && !(g && gid == i);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x1    = '0;
        req_x2    = '0;
        rsp_ready = 1'b0;
        pend      = '0;
        dut_hs    = 0;
        for (int i = 0; i < 4; i++) begin
            nx1[i] = 32'h3F800000;
            nx2[i] = 32'h3F000000;
        end
        do_reset();

        // Single op from requester 0: 1.0 - 0.5.
        do_cycle(4'b0001, 1'b1);
        chk("t1_grant", 32'(req_ready), 32'h1);
        do_cycle(4'b0000, 1'b1);
        chk("t1_not_yet", 32'(rsp_valid), 32'd0);
        do_cycle(4'b0000, 1'b1);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_id",    32'(rsp_id),    32'd0);
        chk("t1_y",     rsp_y,          32'h3F000000);
        chk("t1_ovf",   32'(rsp_ovf),   32'd0);

        // All four streaming: round-robin grants, no bubbles.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_cycle(4'b1111, 1'b1);
            chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk("t2_valid", 32'(rsp_valid), 32'd1);
                chk("t2_id",    32'(rsp_id),    32'((k - 2) % 4));
            end
        end

        // Overflow from requester 2.
        do_reset();
        nx1[2] = 32'h7F7FFFFF;
        nx2[2] = 32'hFF7FFFFF;
        do_cycle(4'b0100, 1'b1);
        do_cycle(4'b0000, 1'b1);
        do_cycle(4'b0000, 1'b1);
        chk("t3_exp", 32'(rsp_y[30:23]), 32'hFF);
        chk("t3_ovf", 32'(rsp_ovf),      32'd1);
        do_cycle(4'b0000, 1'b1);
`ifdef FSUB_ARB_PERF_EN
        chk("t3_perf_ovf", 32'(perf_ovf), 32'd1);
`endif

        // Backpressure on requester 1 stream, then drain.
        do_reset();
        dut_hs = 0;
        nx1[1] = 32'h40000000;
        nx2[1] = 32'h3F800000;
        for (int k = 0; k < 5; k++) begin
            do_cycle(4'b0010, 1'b0);
            if (k < 2) begin
                chk("t4_accept", 32'(req_ready), 32'h2);
            end else begin
                chk("t4_stall", 32'(req_ready), 32'h0);
                chk("t4_held",  rsp_y,          32'h3F800000);
                chk("t4_valid", 32'(rsp_valid), 32'd1);
            end
        end
        for (int k = 0; k < 6; k++) do_cycle(4'b0000, 1'b1);
        chk("t4_drained", 32'(dut_hs), 32'd3);

        // Reset with both stages full discards them; arbitration restarts at 0.
        do_reset();
        for (int k = 0; k < 3; k++) do_cycle(4'b0001, 1'b0);
        chk("t5_busy",  32'(busy),      32'd1);
        chk("t5_valid", 32'(rsp_valid), 32'd1);
        do_reset();
        dut_hs = 0;
        do_cycle(4'b1111, 1'b1);
        chk("t5_grant0", 32'(req_ready), 32'h1);
        for (int k = 0; k < 9; k++) do_cycle(4'b0000, 1'b1);
        chk("t5_rsp_count", 32'(dut_hs), 32'd4);

        // Pointer wrap: after 3, requester 0 beats 3.
        do_reset();
        do_cycle(4'b1000, 1'b1);
        chk("t6_grant3", 32'(req_ready), 32'h8);
        do_cycle(4'b1001, 1'b1);
        chk("t6_grant0", 32'(req_ready), 32'h1);
        do_cycle(4'b0000, 1'b1);
        chk("t6_grant3b", 32'(req_ready), 32'h8);

        // Random traffic with random backpressure and periodic resets.
        for (int k = 0; k < 3000; k++) begin
            if (k % 700 == 699) do_reset();
            for (int i = 0; i < 4; i++) begin
                nx1[i] = $urandom;
                nx2[i] = $urandom;
            end
            do_cycle(4'($urandom), ($urandom % 4) != 0);
        end
        for (int k = 0; k < 6; k++) do_cycle(4'b0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
